// File: rtl/branch_resolve_unit.sv
// Two-stage RV32I conditional branch resolver with valid/ready handshake,
// redirect target computation and handoff statistics.
module branch_resolve_unit #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [31:0]      i_rs1,
    input  logic [31:0]      i_rs2,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_imm,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_taken,
    output logic [31:0]      o_target,
    output logic [31:0]      o_pc_next,
    output logic             o_illegal,
    output logic             o_misaligned,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);

    logic             r_s1_valid;
    logic [2:0]       r_s1_funct3;
    logic [31:0]      r_s1_rs1;
    logic [31:0]      r_s1_rs2;
    logic [31:0]      r_s1_pc;
    logic [31:0]      r_s1_imm;

    logic             r_s2_valid;
    logic             r_taken;
    logic [31:0]      r_target;
    logic [31:0]      r_pc_next;
    logic             r_illegal;
    logic             r_misaligned;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic             w_s1_adv;
    logic             w_s1_free;
    logic             w_accept;
    logic             w_handoff;
    logic             w_eq;
    logic             w_lt_u;
    logic             w_lt_s;
    logic [31:0]      w_target;
    logic [31:0]      w_seq;
    logic             w_taken;
    logic             w_illegal;
    logic             w_misaligned;
    logic [31:0]      w_pc_next;

    assign w_s1_adv  = !r_s2_valid || i_ready;
    assign w_s1_free = !r_s1_valid || w_s1_adv;
    assign o_ready   = !i_rst && w_s1_free;
    assign w_accept  = i_valid && o_ready && !i_flush;
    assign w_handoff = r_s2_valid && i_ready;

    assign w_eq     = (r_s1_rs1 == r_s1_rs2);
    assign w_lt_u   = (r_s1_rs1 < r_s1_rs2);
    // Differing sign bits decide signed order; otherwise unsigned order holds.
    assign w_lt_s   = (r_s1_rs1[31] != r_s1_rs2[31]) ? r_s1_rs1[31] : w_lt_u;
    assign w_target = r_s1_pc + r_s1_imm;
    assign w_seq    = r_s1_pc + 32'd4;

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        unique case (r_s1_funct3)
            3'b000: w_taken = w_eq;
            3'b001: w_taken = !w_eq;
            3'b100: w_taken = w_lt_s;
            3'b101: w_taken = !w_lt_s;
            3'b110: w_taken = w_lt_u;
            3'b111: w_taken = !w_lt_u;
            3'b010,
            3'b011: w_illegal = 1'b1;
        endcase
    end

    assign w_misaligned = w_taken && (w_target[1:0] != 2'b00);
    assign w_pc_next    = w_taken ? w_target : w_seq;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_funct3 <= '0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_pc     <= '0;
            r_s1_imm    <= '0;
        end else begin
            if (i_flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_free) begin
                r_s1_valid <= w_accept;
            end
            if (w_accept) begin
                r_s1_funct3 <= i_funct3;
                r_s1_rs1    <= i_rs1;
                r_s1_rs2    <= i_rs2;
                r_s1_pc     <= i_pc;
                r_s1_imm    <= i_imm;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid   <= 1'b0;
            r_taken      <= 1'b0;
            r_target     <= '0;
            r_pc_next    <= '0;
            r_illegal    <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            if (i_flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s1_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv && r_s1_valid) begin
                r_taken      <= w_taken;
                r_target     <= w_target;
                r_pc_next    <= w_pc_next;
                r_illegal    <= w_illegal;
                r_misaligned <= w_misaligned;
            end
        end
    end

    // A handoff coinciding with a flush still completes and is counted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else if (w_handoff) begin
            r_br_cnt    <= r_br_cnt + 1'b1;
            r_taken_cnt <= r_taken_cnt + CNT_W'(r_taken);
        end
    end

    assign o_valid      = r_s2_valid;
    assign o_taken      = r_taken;
    assign o_target     = r_target;
    assign o_pc_next    = r_pc_next;
    assign o_illegal    = r_illegal;
    assign o_misaligned = r_misaligned;
    assign o_br_cnt     = r_br_cnt;
    assign o_taken_cnt  = r_taken_cnt;

endmodule
